// File: rtl/atpg_test_sequencer_pkg.sv
// rtl/atpg_test_sequencer_pkg.sv - shared widths, FSM states and golden responses for the ATPG sequencer
package atpg_test_sequencer_pkg;

  localparam int PAT_W   = 3;
  localparam int MAX_PAT = 8;
  localparam int IDX_W   = $clog2(MAX_PAT);
  localparam int CNT_W   = 4;

  // Fault-free {X,Y,Z}: 001 when A=B=1, 111 for every other stimulus
  localparam logic [PAT_W-1:0] GOLD_AB    = 3'b001;
  localparam logic [PAT_W-1:0] GOLD_OTHER = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  function automatic logic [IDX_W-1:0] last_index(input logic mode, input logic [CNT_W-1:0] num_pat);
    if (!mode)
      return IDX_W'(MAX_PAT - 1);
    if (num_pat == '0)
      return '0;
    if (num_pat > CNT_W'(MAX_PAT))
      return IDX_W'(MAX_PAT - 1);
    return IDX_W'(num_pat - CNT_W'(1));
  endfunction

endpackage

// File: rtl/atpg_test_sequencer_if.sv
// rtl/atpg_test_sequencer_if.sv - control, list-load, CUT and result signals of the ATPG sequencer
interface atpg_test_sequencer_if;
  import atpg_test_sequencer_pkg::*;

  logic                 start;
  logic                 abort;
  logic                 mode;
  logic [CNT_W-1:0]     num_pat;
  logic                 load_we;
  logic [IDX_W-1:0]     load_addr;
  logic [PAT_W-1:0]     load_pat;
  logic [PAT_W-1:0]     load_exp;
  logic [PAT_W-1:0]     cut_in;
  logic [PAT_W-1:0]     cut_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     fail_count;
  logic [IDX_W-1:0]     first_fail_idx;
  logic [PAT_W-1:0]     first_fail_resp;

  modport master (
    output start, abort, mode, num_pat, load_we, load_addr, load_pat, load_exp, cut_out,
    input  cut_in, busy, done, pass, fail_count, first_fail_idx, first_fail_resp
  );

  modport slave (
    input  start, abort, mode, num_pat, load_we, load_addr, load_pat, load_exp, cut_out,
    output cut_in, busy, done, pass, fail_count, first_fail_idx, first_fail_resp
  );

endinterface

// File: rtl/atpg_test_sequencer_cut_golden.sv
// rtl/atpg_test_sequencer_cut_golden.sv - fault-free response of the circuit under test
module cut_golden
  import atpg_test_sequencer_pkg::*;
(
  input  logic [PAT_W-1:0] stim,
  output logic [PAT_W-1:0] resp
);

  assign resp = (stim[2] && stim[1]) ? GOLD_AB : GOLD_OTHER;

endmodule

// File: rtl/atpg_test_sequencer.sv
// rtl/atpg_test_sequencer.sv - applies exhaustive or stored patterns to a CUT and scores its responses
module atpg_test_sequencer
  import atpg_test_sequencer_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  atpg_test_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [PAT_W-1:0] cut_in_q, cut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
  logic [PAT_W-1:0] ff_resp_q, ff_resp_d;

  logic [PAT_W-1:0] mem_pat_q [MAX_PAT];
  logic [PAT_W-1:0] mem_exp_q [MAX_PAT];

  logic [PAT_W-1:0] gold_resp;
  logic [PAT_W-1:0] exp_resp;
  logic [IDX_W-1:0] idx_inc;

  cut_golden u_golden (
    .stim (cut_in_q),
    .resp (gold_resp)
  );

  assign exp_resp = mode_q ? mem_exp_q[idx_q] : gold_resp;
  assign idx_inc  = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    cut_in_d  = cut_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_resp_d = ff_resp_q;

    // busy_q is high exactly in APPLY/WAIT/CAPTURE, the states abort can cut short
    if (busy_q && bus.abort) begin
      state_d  = ST_DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      pass_d   = 1'b0;
      cut_in_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_APPLY;
            idx_d     = '0;
            mode_d    = bus.mode;
            last_d    = last_index(bus.mode, bus.num_pat);
            busy_d    = 1'b1;
            pass_d    = 1'b0;
            fail_d    = '0;
            ff_idx_d  = '0;
            ff_resp_d = '0;
            cut_in_d  = bus.mode ? mem_pat_q[0] : '0;
          end
        end
        ST_APPLY: begin
          cnt_d   = SETTLE_M1;
          state_d = (SETTLE > 1) ? ST_WAIT : ST_CAPTURE;
        end
        ST_WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1))
            state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (bus.cut_out != exp_resp) begin
            fail_d = fail_q + CNT_W'(1);
            if (fail_q == '0) begin
              ff_idx_d  = idx_q;
              ff_resp_d = bus.cut_out;
            end
          end
          if (idx_q == last_q) begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (fail_d == '0);
            cut_in_d = '0;
          end else begin
            state_d  = ST_APPLY;
            idx_d    = idx_inc;
            cut_in_d = mode_q ? mem_pat_q[idx_inc] : PAT_W'(idx_inc);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      cut_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_resp_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      cut_in_q  <= cut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ff_idx_q  <= ff_idx_d;
      ff_resp_q <= ff_resp_d;
    end
  end

  // Pattern list survives reset so a tester can rerun without reloading
  always_ff @(posedge clk) begin
    if (bus.load_we && state_q == ST_IDLE) begin
      mem_pat_q[bus.load_addr] <= bus.load_pat;
      mem_exp_q[bus.load_addr] <= bus.load_exp;
    end
  end

  assign bus.cut_in          = cut_in_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.fail_count      = fail_q;
  assign bus.first_fail_idx  = ff_idx_q;
  assign bus.first_fail_resp = ff_resp_q;

endmodule
